// File: rtl/grf_hazard_scoreboard.sv
// Read-after-write scoreboard for the GRF plus the mult/div busy counter.
// It holds the D stage with a combinational stall whenever a source operand is not ready in time.
module grf_hazard_scoreboard #(
    parameter int LIFE        = 3,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rs,
    input  logic [4:0]  issue_rt,
    input  logic        issue_use_rs,
    input  logic        issue_use_rt,
    input  logic [1:0]  issue_tuse_rs,
    input  logic [1:0]  issue_tuse_rt,
    input  logic        issue_we,
    input  logic [4:0]  issue_dst,
    input  logic [1:0]  issue_tnew,
    input  logic        issue_md_use,
    input  logic        issue_md_start,
    input  logic        issue_md_div,
    output logic        stall,
    output logic        md_busy,
    output logic [31:0] pending_mask
);

    localparam int LIFE_W = $clog2(LIFE + 1);
    localparam int MD_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int MD_W   = $clog2(MD_MAX + 1);

    // Register 0 has no storage: the arrays only cover 1..31.
    logic [1:0]        r_tnew [1:31];
    logic [LIFE_W-1:0] r_life [1:31];
    logic [MD_W-1:0]   r_md_cnt;

    logic [1:0] w_tnew_rs;
    logic [1:0] w_tnew_rt;
    logic       w_live_rs;
    logic       w_live_rt;
    logic       w_hz_rs;
    logic       w_hz_rt;
    logic       w_hz_md;
    logic       w_accept;

    // Lookup of the current source registers; index 0 never matches, so $0 reads as idle.
    always_comb begin
        w_tnew_rs = 2'd0;
        w_tnew_rt = 2'd0;
        w_live_rs = 1'b0;
        w_live_rt = 1'b0;
        pending_mask = 32'd0;
        for (int r = 1; r < 32; r++) begin
            pending_mask[r] = (r_life[r] != '0);
            if (issue_rs == 5'(r)) begin
                w_tnew_rs = r_tnew[r];
                w_live_rs = (r_life[r] != '0);
            end
            if (issue_rt == 5'(r)) begin
                w_tnew_rt = r_tnew[r];
                w_live_rt = (r_life[r] != '0);
            end
        end
    end

    // Handshake: an instruction is taken on a rising edge when issue_valid=1 and stall=0;
    // while stalled the D stage must hold its inputs stable and nothing here is updated.
    assign md_busy  = (r_md_cnt != '0);
    assign w_hz_rs  = issue_use_rs & w_live_rs & (w_tnew_rs > issue_tuse_rs);
    assign w_hz_rt  = issue_use_rt & w_live_rt & (w_tnew_rt > issue_tuse_rt);
    assign w_hz_md  = issue_md_use & md_busy;
    assign stall    = issue_valid & (w_hz_rs | w_hz_rt | w_hz_md);
    assign w_accept = issue_valid & ~stall;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int r = 1; r < 32; r++) begin
                r_tnew[r] <= 2'd0;
                r_life[r] <= '0;
            end
            r_md_cnt <= '0;
        end else if (clear) begin
            for (int r = 1; r < 32; r++) begin
                r_tnew[r] <= 2'd0;
                r_life[r] <= '0;
            end
            r_md_cnt <= '0;
        end else begin
            for (int r = 1; r < 32; r++) begin
                // A new writer replaces whatever older writer of the same register is still tracked.
                if (w_accept && issue_we && (issue_dst == 5'(r))) begin
                    r_tnew[r] <= issue_tnew;
                    r_life[r] <= LIFE_W'(LIFE);
                end else begin
                    r_tnew[r] <= (r_tnew[r] != 2'd0) ? r_tnew[r] - 2'd1 : 2'd0;
                    r_life[r] <= (r_life[r] != '0) ? r_life[r] - LIFE_W'(1) : '0;
                end
            end
            if (w_accept && issue_md_start) begin
                r_md_cnt <= issue_md_div ? MD_W'(DIV_CYCLES) : MD_W'(MULT_CYCLES);
            end else if (r_md_cnt != '0) begin
                r_md_cnt <= r_md_cnt - MD_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_grf_hazard_scoreboard.sv
// Directed bench for grf_hazard_scoreboard: inputs change and outputs are sampled around the
// falling edge, so every rising edge sees settled stimulus.
module tb_grf_hazard_scoreboard;

    logic        clk;
    logic        reset;
    logic        clear;
    logic        issue_valid;
    logic [4:0]  issue_rs;
    logic [4:0]  issue_rt;
    logic        issue_use_rs;
    logic        issue_use_rt;
    logic [1:0]  issue_tuse_rs;
    logic [1:0]  issue_tuse_rt;
    logic        issue_we;
    logic [4:0]  issue_dst;
    logic [1:0]  issue_tnew;
    logic        issue_md_use;
    logic        issue_md_start;
    logic        issue_md_div;
    logic        stall;
    logic        md_busy;
    logic [31:0] pending_mask;

    int n_cmp;
    int n_bad;

    grf_hazard_scoreboard dut (
        .clk            (clk),
        .reset          (reset),
        .clear          (clear),
        .issue_valid    (issue_valid),
        .issue_rs       (issue_rs),
        .issue_rt       (issue_rt),
        .issue_use_rs   (issue_use_rs),
        .issue_use_rt   (issue_use_rt),
        .issue_tuse_rs  (issue_tuse_rs),
        .issue_tuse_rt  (issue_tuse_rt),
        .issue_we       (issue_we),
        .issue_dst      (issue_dst),
        .issue_tnew     (issue_tnew),
        .issue_md_use   (issue_md_use),
        .issue_md_start (issue_md_start),
        .issue_md_div   (issue_md_div),
        .stall          (stall),
        .md_busy        (md_busy),
        .pending_mask   (pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drv(input logic v, input logic [4:0] rs, input logic urs, input logic [1:0] trs,
                       input logic [4:0] rt, input logic urt, input logic [1:0] trt,
                       input logic we, input logic [4:0] dst, input logic [1:0] tn,
                       input logic mdu, input logic mds, input logic mdd);
        issue_valid    = v;
        issue_rs       = rs;
        issue_use_rs   = urs;
        issue_tuse_rs  = trs;
        issue_rt       = rt;
        issue_use_rt   = urt;
        issue_tuse_rt  = trt;
        issue_we       = we;
        issue_dst      = dst;
        issue_tnew     = tn;
        issue_md_use   = mdu;
        issue_md_start = mds;
        issue_md_div   = mdd;
    endtask

    task automatic idle();
        drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic clean();
        idle();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        clear = 1'b0;
        idle();
        repeat (2) @(negedge clk);
        drv(1, 3, 1, 0, 4, 1, 0, 0, 0, 0, 1, 0, 0);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall got=%b want=0", stall); end
        n_cmp++; if (md_busy !== 1'b0) begin n_bad++; $display("FAIL reset_md_busy got=%b want=0", md_busy); end
        n_cmp++; if (pending_mask !== 32'd0) begin n_bad++; $display("FAIL reset_mask got=%h want=0", pending_mask); end
        idle();
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_use();
        clean();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 8, 2, 0, 0, 0);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_lw_stall got=%b want=0", stall); end
        @(negedge clk);
        drv(1, 8, 1, 1, 0, 0, 0, 1, 10, 1, 0, 0, 0);
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL lu_addu_stall1 got=%b want=1", stall); end
        n_cmp++; if (pending_mask !== 32'h0000_0100) begin n_bad++; $display("FAIL lu_mask1 got=%h want=00000100", pending_mask); end
        @(negedge clk);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL lu_addu_stall2 got=%b want=0", stall); end
        n_cmp++; if (pending_mask !== 32'h0000_0100) begin n_bad++; $display("FAIL lu_mask2 got=%h want=00000100", pending_mask); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (pending_mask !== 32'h0000_0500) begin n_bad++; $display("FAIL lu_mask3 got=%h want=00000500", pending_mask); end
        @(negedge clk);
        #1;
        n_cmp++; if (pending_mask !== 32'h0000_0400) begin n_bad++; $display("FAIL lu_mask4 got=%h want=00000400", pending_mask); end
    endtask

    task automatic test_forwardable();
        clean();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0);
        @(negedge clk);
        drv(1, 9, 1, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (stall !== 1'b1) begin n_bad++; $display("FAIL fw_beq_stall1 got=%b want=1", stall); end
        @(negedge clk);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fw_beq_stall2 got=%b want=0", stall); end
        @(negedge clk);
        clean();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 9, 1, 0, 0, 0);
        @(negedge clk);
        drv(1, 29, 1, 1, 9, 1, 2, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fw_sw_stall got=%b want=0", stall); end
        @(negedge clk);
    endtask

    task automatic test_zero_and_waw();
        clean();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0);
        @(negedge clk);
        drv(1, 0, 1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL r0_stall got=%b want=0", stall); end
        n_cmp++; if (pending_mask !== 32'd0) begin n_bad++; $display("FAIL r0_mask got=%h want=0", pending_mask); end
        clean();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 5, 2, 0, 0, 0);
        @(negedge clk);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 5, 1, 0, 0, 0);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL waw_addu_stall got=%b want=0", stall); end
        @(negedge clk);
        drv(1, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL waw_reader_stall got=%b want=0", stall); end
        @(negedge clk);
        idle();
        @(negedge clk);
        #1;
        // Second writer restarted the lifetime, so $5 is still pending here.
        n_cmp++; if (pending_mask[5] !== 1'b1) begin n_bad++; $display("FAIL waw_life got=%b want=1", pending_mask[5]); end
    endtask

    task automatic test_mult_div();
        int n_st;
        int n_busy;
        clean();
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL md_div_stall got=%b want=0", stall); end
        @(negedge clk);
        drv(1, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 0, 0);
        n_st = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!stall) break;
            n_st++;
            @(negedge clk);
        end
        n_cmp++; if (n_st !== 10) begin n_bad++; $display("FAIL md_mflo_stall_cycles got=%0d want=10", n_st); end
        @(negedge clk);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL md_mult_stall got=%b want=0", stall); end
        @(negedge clk);
        idle();
        n_busy = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!md_busy) break;
            n_busy++;
            @(negedge clk);
        end
        n_cmp++; if (n_busy !== 5) begin n_bad++; $display("FAIL md_mult_busy_cycles got=%0d want=5", n_busy); end
    endtask

    task automatic test_flush();
        clean();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 3, 2, 0, 0, 0);
        @(negedge clk);
        drv(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1);
        @(negedge clk);
        drv(0, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        #1;
        n_cmp++; if (md_busy !== 1'b1) begin n_bad++; $display("FAIL fl_pre_busy got=%b want=1", md_busy); end
        n_cmp++; if (pending_mask !== 32'h0000_0008) begin n_bad++; $display("FAIL fl_pre_mask got=%h want=00000008", pending_mask); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fl_novalid_stall got=%b want=0", stall); end
        clear = 1'b1;
        drv(1, 0, 0, 0, 0, 0, 0, 1, 7, 1, 0, 0, 0);
        @(negedge clk);
        clear = 1'b0;
        drv(1, 3, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        #1;
        n_cmp++; if (pending_mask !== 32'd0) begin n_bad++; $display("FAIL fl_mask got=%h want=0", pending_mask); end
        n_cmp++; if (md_busy !== 1'b0) begin n_bad++; $display("FAIL fl_busy got=%b want=0", md_busy); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL fl_reader_stall got=%b want=0", stall); end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        clean();
        drv(1, 0, 0, 0, 0, 0, 0, 1, 4, 2, 1, 1, 1);
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (md_busy !== 1'b1) begin n_bad++; $display("FAIL ar_pre_busy got=%b want=1", md_busy); end
        n_cmp++; if (pending_mask !== 32'h0000_0010) begin n_bad++; $display("FAIL ar_pre_mask got=%h want=00000010", pending_mask); end
        #1;
        reset = 1'b0;
        drv(1, 4, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        #1;
        n_cmp++; if (md_busy !== 1'b0) begin n_bad++; $display("FAIL ar_busy got=%b want=0", md_busy); end
        n_cmp++; if (pending_mask !== 32'd0) begin n_bad++; $display("FAIL ar_mask got=%h want=0", pending_mask); end
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ar_stall_in_reset got=%b want=0", stall); end
        @(negedge clk);
        reset = 1'b1;
        drv(1, 4, 1, 0, 0, 0, 0, 1, 6, 1, 1, 0, 0);
        #1;
        n_cmp++; if (stall !== 1'b0) begin n_bad++; $display("FAIL ar_first_stall got=%b want=0", stall); end
        @(negedge clk);
        idle();
        #1;
        n_cmp++; if (pending_mask !== 32'h0000_0040) begin n_bad++; $display("FAIL ar_first_mask got=%h want=00000040", pending_mask); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_load_use();
        test_forwardable();
        test_zero_and_waw();
        test_mult_div();
        test_flush();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
